// File: rtl/rsu_pkg.sv
// Shared definitions for the result select unit: funct codes, source-select
// encoding and FSM state encoding.
package rsu_pkg;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  typedef enum logic [2:0] {
    SRC_ALU,
    SRC_HI,
    SRC_LO,
    SRC_SHIFT,
    SRC_NONE,
    SRC_ILLEGAL
  } rsu_src_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FULL,
    ST_WAIT_DIV
  } rsu_state_e;

endpackage

// File: rtl/rsu_decode.sv
// Combinational funct -> result source decode. Codes wider than 6 bits must
// carry zeros above bit 5 to match a supported operation.
module rsu_decode
  import rsu_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [FUNCT_W-1:0] funct,
  output rsu_src_e           sel
);

  // Map each supported funct to its source; everything else is illegal.
  always_comb begin
    sel = SRC_ILLEGAL;
    case (funct)
      FUNCT_W'(F_ADD),
      FUNCT_W'(F_SUB),
      FUNCT_W'(F_AND),
      FUNCT_W'(F_OR),
      FUNCT_W'(F_SLT):  sel = SRC_ALU;
      FUNCT_W'(F_MFHI): sel = SRC_HI;
      FUNCT_W'(F_MFLO): sel = SRC_LO;
      FUNCT_W'(F_SLL):  sel = SRC_SHIFT;
      FUNCT_W'(F_DIVU): sel = SRC_NONE;
      default:          sel = SRC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/result_select_unit.sv
// Registered writeback selector. Picks ALU / Hi / Lo / shifter result per
// accepted funct into a one-entry output register, interlocking MFHI/MFLO
// against the divider. Optional stall counter under `RSU_STATS_EN.
//
// Handshake: a funct transfers on a cycle where in_valid && in_ready; a result
// transfers on a cycle where out_valid && out_ready. in_ready depends only on
// state and out_ready, never on in_valid. out_valid/data_out/out_illegal are
// held unchanged while out_valid && !out_ready.
module result_select_unit
  import rsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [WIDTH-1:0]   hi_out,
  input  logic [WIDTH-1:0]   lo_out,
  input  logic [WIDTH-1:0]   shift_out,
  input  logic               div_busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               out_illegal,
`ifdef RSU_STATS_EN
  output logic [15:0]        stall_cnt,
`endif
  output logic [1:0]         dbg_state
);

  rsu_state_e       state_q, state_d;
  rsu_src_e         dec_sel, load_src;
  logic             pend_lo_q, pend_lo_d;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] data_q, load_data;
  logic             ill_q;

  rsu_decode #(.FUNCT_W(FUNCT_W)) u_decode (
    .funct (funct),
    .sel   (dec_sel)
  );

  assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_FULL) && out_ready);
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == ST_FULL);
  assign data_out    = data_q;
  assign out_illegal = ill_q;
  assign dbg_state   = state_q;

  // Next state, load strobe and the source to load from.
  always_comb begin
    state_d   = state_q;
    pend_lo_d = pend_lo_q;
    load      = 1'b0;
    load_src  = dec_sel;
    case (state_q)
      ST_WAIT_DIV: begin
        if (!div_busy) begin
          load     = 1'b1;
          load_src = pend_lo_q ? SRC_LO : SRC_HI;
          state_d  = ST_FULL;
        end
      end
      default: begin
        if (accept) begin
          if (dec_sel == SRC_NONE) begin
            // DIVU produces no beat; from FULL the old beat drains this cycle.
            state_d = ST_IDLE;
          end else if (((dec_sel == SRC_HI) || (dec_sel == SRC_LO)) && div_busy) begin
            pend_lo_d = (dec_sel == SRC_LO);
            state_d   = ST_WAIT_DIV;
          end else begin
            load    = 1'b1;
            state_d = ST_FULL;
          end
        end else if ((state_q == ST_FULL) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Source mux feeding the output register.
  always_comb begin
    load_data = '0;
    case (load_src)
      SRC_ALU:   load_data = alu_out;
      SRC_HI:    load_data = hi_out;
      SRC_LO:    load_data = lo_out;
      SRC_SHIFT: load_data = shift_out;
      default:   load_data = '0;
    endcase
  end

  // State, pending MF selector and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_lo_q <= 1'b0;
      data_q    <= '0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_lo_q <= pend_lo_d;
      if (load) begin
        data_q <= load_data;
        ill_q  <= (load_src == SRC_ILLEGAL);
      end
    end
  end

`ifdef RSU_STATS_EN
  // Saturating count of divider-wait cycles plus back-pressured full cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (((state_q == ST_WAIT_DIV) || ((state_q == ST_FULL) && !out_ready))
                 && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_result_select_unit.sv
// Testbench for result_select_unit: directed scenarios plus a randomized run
// checked against a slot-level behavioural model.
module tb_result_select_unit;

  localparam int W = 32;

  localparam logic [5:0] C_ADD  = 6'b100000;
  localparam logic [5:0] C_SUB  = 6'b100010;
  localparam logic [5:0] C_AND  = 6'b100100;
  localparam logic [5:0] C_OR   = 6'b100101;
  localparam logic [5:0] C_SLT  = 6'b101010;
  localparam logic [5:0] C_SLL  = 6'b000000;
  localparam logic [5:0] C_DIVU = 6'b011011;
  localparam logic [5:0] C_MFHI = 6'b010000;
  localparam logic [5:0] C_MFLO = 6'b010010;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   funct;
  logic [W-1:0] alu_out, hi_out, lo_out, shift_out;
  logic         div_busy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_out;
  logic         out_illegal;
  logic [1:0]   dbg_state;
`ifdef RSU_STATS_EN
  logic [15:0]  stall_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  result_select_unit #(.WIDTH(W), .FUNCT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .funct       (funct),
    .alu_out     (alu_out),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .shift_out   (shift_out),
    .div_busy    (div_busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .out_illegal (out_illegal),
`ifdef RSU_STATS_EN
    .stall_cnt   (stall_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid  = 1'b0;
    funct     = C_SLL;
    alu_out   = '0;
    hi_out    = '0;
    lo_out    = '0;
    shift_out = '0;
    div_busy  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Spec-level classification: 0 alu, 1 hi, 2 lo, 3 shift, 4 no beat, 5 illegal.
  function automatic int kind_of(logic [5:0] f);
    if (f == C_ADD || f == C_SUB || f == C_AND || f == C_OR || f == C_SLT) return 0;
    if (f == C_MFHI) return 1;
    if (f == C_MFLO) return 2;
    if (f == C_SLL)  return 3;
    if (f == C_DIVU) return 4;
    return 5;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests_run++; if (data_out !== '0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", data_out); end
    tests_run++; if (out_illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal: got %b want 0", out_illegal); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef RSU_STATS_EN
    tests_run++; if (stall_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_add();
    next_cycle();
    in_valid = 1'b1; funct = C_ADD; alu_out = 32'h0000_0007; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0; alu_out = 32'h1234_5678;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL add_valid: got %b want 1", out_valid); end
    tests_run++; if (data_out !== 32'h7) begin tests_failed++; $display("FAIL add_data: got %h want 7", data_out); end
    tests_run++; if (out_illegal !== 1'b0) begin tests_failed++; $display("FAIL add_illegal: got %b want 0", out_illegal); end
    next_cycle();
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL add_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sh;
    sh = W'($urandom);
    next_cycle();
    in_valid = 1'b1; funct = C_SLL; shift_out = sh; lo_out = 32'hDEAD_BEEF; div_busy = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
    next_cycle();
    funct = C_MFLO; shift_out = ~sh;
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
    tests_run++; if (out_valid !== 1'b1 || data_out !== sh) begin tests_failed++; $display("FAIL b2b_sll: got v=%b %h want v=1 %h", out_valid, data_out, sh); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1 || data_out !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL b2b_mflo: got v=%b %h want v=1 deadbeef", out_valid, data_out); end
    next_cycle();
  endtask

  task automatic test_interlock();
    apply_reset();
    in_valid = 1'b1; funct = C_MFHI; div_busy = 1'b1; hi_out = 32'hBAD0_0000; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    // Cycles 1..4 busy, cycle 5 busy falls with Hi final.
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin div_busy = 1'b0; hi_out = 32'h0000_0003; end
      else hi_out = W'($urandom);
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL intlk_ready c%0d: got %b want 0", c, in_ready); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL intlk_valid c%0d: got %b want 0", c, out_valid); end
      next_cycle();
    end
    hi_out = 32'hFFFF_0000;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1 || data_out !== 32'h3) begin tests_failed++; $display("FAIL intlk_data: got v=%b %h want v=1 3", out_valid, data_out); end
`ifdef RSU_STATS_EN
    tests_run++; if (stall_cnt !== 16'd5) begin tests_failed++; $display("FAIL intlk_stall: got %0d want 5", stall_cnt); end
`endif
    next_cycle();
  endtask

  task automatic test_hold();
    logic [W-1:0] x, y;
    x = W'($urandom); y = W'($urandom);
    in_valid = 1'b1; funct = C_OR; alu_out = x; out_ready = 1'b0;
    next_cycle();
    funct = C_ADD;
    for (int c = 0; c < 3; c++) begin
      alu_out = W'($urandom);
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b1 || data_out !== x) begin tests_failed++; $display("FAIL hold_data c%0d: got v=%b %h want v=1 %h", c, out_valid, data_out, x); end
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_ready c%0d: got %b want 0", c, in_ready); end
      next_cycle();
    end
    out_ready = 1'b1; alu_out = y;
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1 || data_out !== y) begin tests_failed++; $display("FAIL hold_next: got v=%b %h want v=1 %h", out_valid, data_out, y); end
    next_cycle();
  endtask

  task automatic test_illegal_divu();
    in_valid = 1'b1; funct = 6'b111111; alu_out = W'($urandom); shift_out = W'($urandom); out_ready = 1'b1;
    next_cycle();
    funct = C_DIVU;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1 || data_out !== '0 || out_illegal !== 1'b1) begin tests_failed++; $display("FAIL illegal: got v=%b %h ill=%b want v=1 0 ill=1", out_valid, data_out, out_illegal); end
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL divu_novalid c%0d: got %b want 0", c, out_valid); end
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_wait();
    in_valid = 1'b1; funct = C_MFHI; div_busy = 1'b1; hi_out = 32'h5555_AAAA; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstwait_valid: got %b want 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstwait_ready: got %b want 1", in_ready); end
    next_cycle();
    rst_n = 1'b1; div_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstwait_stale c%0d: got %b want 0", c, out_valid); end
      next_cycle();
    end
  endtask

  // Randomized run; model tracks the output slot and any divider-pending read.
  task automatic test_random();
    logic [W-1:0] exp_q[$];
    logic         exp_ill_q[$];
    bit           waiting, wait_lo, exp_rdy;
    int           busy_left, k;
    int           stall_m;
    logic [5:0]   codes[9];
    codes = '{C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_SLL, C_DIVU, C_MFHI, C_MFLO};
    apply_reset();
    waiting = 0; wait_lo = 0; busy_left = 0; stall_m = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      k         = $urandom_range(0, 9);
      funct     = (k == 9) ? 6'($urandom) : codes[k];
      alu_out   = W'($urandom);
      hi_out    = W'($urandom);
      lo_out    = W'($urandom);
      shift_out = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (busy_left > 0) busy_left--;
      else if ($urandom_range(0, 7) == 0) busy_left = $urandom_range(1, 6);
      div_busy = (busy_left > 0);
      @(negedge clk);
      exp_rdy = !waiting && (exp_q.size() == 0 || out_ready);
      tests_run++; if (in_ready !== exp_rdy) begin tests_failed++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, in_ready, exp_rdy); end
      tests_run++; if (out_valid !== (exp_q.size() != 0)) begin tests_failed++; $display("FAIL rnd_valid cyc%0d: got %b want %b", cyc, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        tests_run++; if (data_out !== exp_q[0] || out_illegal !== exp_ill_q[0]) begin tests_failed++; $display("FAIL rnd_data cyc%0d: got %h ill=%b want %h ill=%b", cyc, data_out, out_illegal, exp_q[0], exp_ill_q[0]); end
      end
`ifdef RSU_STATS_EN
      tests_run++; if (stall_cnt !== 16'(stall_m)) begin tests_failed++; $display("FAIL rnd_stall cyc%0d: got %0d want %0d", cyc, stall_cnt, stall_m); end
`endif
      // Advance the model across the coming edge.
      if (waiting || (exp_q.size() != 0 && !out_ready)) stall_m = (stall_m < 65535) ? stall_m + 1 : 65535;
      if (waiting) begin
        if (!div_busy) begin
          exp_q.push_back(wait_lo ? lo_out : hi_out);
          exp_ill_q.push_back(1'b0);
          waiting = 0;
        end
      end else begin
        if (exp_q.size() != 0 && out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_ill_q.pop_front());
        end
        if (in_valid && exp_rdy) begin
          case (kind_of(funct))
            0: begin exp_q.push_back(alu_out); exp_ill_q.push_back(1'b0); end
            1, 2: begin
              if (div_busy) begin waiting = 1; wait_lo = (kind_of(funct) == 2); end
              else begin exp_q.push_back(kind_of(funct) == 2 ? lo_out : hi_out); exp_ill_q.push_back(1'b0); end
            end
            3: begin exp_q.push_back(shift_out); exp_ill_q.push_back(1'b0); end
            4: ;
            default: begin exp_q.push_back('0); exp_ill_q.push_back(1'b1); end
          endcase
        end
      end
      next_cycle();
    end
    drive_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_add();
    test_back_to_back();
    test_interlock();
    test_hold();
    test_illegal_divu();
    test_reset_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #2000000;
    tests_failed++;
    $display("FAIL watchdog: got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
